// File: rtl/pixel_plotter.sv
// Clips a shape generator's (x, y) stream to the screen, buffers surviving pixels
// in a show-ahead FIFO and writes them to framebuffer memory over valid/ready.
module pixel_plotter #(
   parameter int SCREEN_W   = 64,
   parameter int SCREEN_H   = 48,
   parameter int ADDR_W     = 12,
   parameter int COLOR_W    = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                _clock,
   input  logic                _reset_n,
   input  logic                _start,
   input  logic [COLOR_W-1:0]  color,
   input  logic                in_valid,
   input  logic signed [31:0]  in_x,
   input  logic signed [31:0]  in_y,
   input  logic                in_done,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [COLOR_W-1:0]  mem_data,
   input  logic                mem_ready,
   output logic                _done,
   output logic [CNT_W-1:0]    pixel_count,
   output logic [CNT_W-1:0]    clip_count,
   output logic                overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                      state;
   logic [COLOR_W-1:0]          color_q;
   logic [PW:0]                 wr_ptr;
   logic [PW:0]                 rd_ptr;
   logic [ADDR_W+COLOR_W-1:0]   fifo_mem [FIFO_DEPTH];

   logic                        empty;
   logic                        full;
   logic                        active;
   logic                        in_range;
   logic                        take;
   logic                        push;
   logic                        pop;
   logic                        clip;
   logic                        drop;
   logic [ADDR_W-1:0]           push_addr;
   logic [ADDR_W-1:0]           head_addr;
   logic [COLOR_W-1:0]          head_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   always_comb begin
      empty     = (wr_ptr == rd_ptr);
      full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      active    = (state == RUN) || (state == DRAIN);
      {head_addr, head_data} = fifo_mem[rd_ptr[PW-1:0]];
      mem_we    = active && !empty;
      mem_addr  = mem_we ? head_addr : '0;
      mem_data  = mem_we ? head_data : '0;
      pop       = mem_we && mem_ready;
      in_range  = (in_x >= 0) && (in_x < SCREEN_W) && (in_y >= 0) && (in_y < SCREEN_H);
      take      = (state == RUN) && in_valid;
      clip      = take && !in_range;
      push      = take && in_range && (!full || pop);
      drop      = take && in_range && full && !pop;
      push_addr = ADDR_W'(in_y * SCREEN_W + in_x);
   end

   always_ff @(posedge _clock) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {push_addr, color_q};
   end

   always_ff @(posedge _clock) begin
      if (!_reset_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         color_q     <= '0;
         pixel_count <= '0;
         clip_count  <= '0;
         overflow    <= 1'b0;
         _done       <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            pixel_count <= sat_inc(pixel_count);
         end
         if (clip) clip_count <= sat_inc(clip_count);
         if (drop) overflow <= 1'b1;
         // pop/clip/drop only occur in RUN or DRAIN, so the clears below never collide
         case (state)
            IDLE, DONE: begin
               if (_start) begin
                  state       <= RUN;
                  color_q     <= color;
                  pixel_count <= '0;
                  clip_count  <= '0;
                  overflow    <= 1'b0;
                  _done       <= 1'b0;
               end
            end
            RUN: begin
               if (in_done) state <= DRAIN;
            end
            DRAIN: begin
               if (empty) begin
                  state <= DONE;
                  _done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pixel_plotter.md
Name: pixel_plotter

Overview:
- Downstream consumer of the shape generators (draw_rectangle and similar). It takes the per-cycle (x, y) coordinate stream plus the generator's done flag.
- Each coordinate is clipped against screen bounds. Surviving pixels are converted to a linear framebuffer address.
- Pixel writes are buffered in a small FIFO and issued to framebuffer memory over a valid/ready write port.
- The block reports completion, a written-pixel count, a clipped-pixel count and a sticky overflow flag.

Parameters:
SCREEN_W, 64, screen width in pixels
SCREEN_H, 48, screen height in pixels
ADDR_W, 12, framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
COLOR_W, 8, pixel colour width
FIFO_DEPTH, 8, write buffer entries (power of two, >=2)
CNT_W, 16, width of the statistics counters

Ports:
_clock  input  1  clock, all state on rising edge
_reset_n  input  1  synchronous active-low reset
_start  input  1  begin a new shape; sampled only in IDLE or DONE
color  input  COLOR_W  colour latched on accepted _start
in_valid  input  1  in_x/in_y carry a coordinate this cycle
in_x  input  32  x coordinate, signed two's complement
in_y  input  32  y coordinate, signed two's complement
in_done  input  1  generator finished; last coordinate may coincide
mem_we  output  1  write request valid
mem_addr  output  ADDR_W  write address
mem_data  output  COLOR_W  write data
mem_ready  input  1  memory accepts the write this cycle
_done  output  1  shape fully written; held until next accepted _start
pixel_count  output  CNT_W  completed memory writes this shape
clip_count  output  CNT_W  coordinates discarded by clipping
overflow  output  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-low.
- Reset values: state=IDLE; FIFO empty; mem_we=0; mem_addr=0; mem_data=0; _done=0; pixel_count=0; clip_count=0; overflow=0; colour latch=0.
- Reset mid-operation: FIFO is flushed, any pending write is abandoned with no handshake completed, and all outputs return to reset values on the next edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, _start=1: latch color; clear pixel_count, clip_count, overflow and _done; go to RUN.
- _start is ignored in RUN and DRAIN. In IDLE and DONE, in_valid and in_done are ignored.
- RUN: each cycle with in_valid=1 evaluates one coordinate.
  - Clipped if in_x<0, in_x>=SCREEN_W, in_y<0 or in_y>=SCREEN_H (signed compares).
  - A clipped coordinate increments clip_count and is not pushed.
  - Otherwise push {addr = in_y*SCREEN_W + in_x, truncated to ADDR_W; data = latched colour}.
- RUN with in_done=1: go to DRAIN. A coordinate valid in the same cycle is still processed.
- DRAIN: no further input is accepted. Go to DONE on the edge where the FIFO is empty and no write is pending.
  - An empty FIFO on entry to DRAIN reaches DONE one cycle after in_done.
- DONE: _done=1; mem_we=0.
- Write port:
  - The FIFO is show-ahead. mem_we = FIFO not empty, in RUN or DRAIN only.
  - mem_addr and mem_data are the FIFO head and stay stable while mem_we=1 and mem_ready=0.
  - A transfer occurs on an edge with mem_we && mem_ready. That edge pops the head and increments pixel_count.
  - mem_ready while mem_we=0 has no effect.
- Latency: an unclipped coordinate valid at edge N with the FIFO empty gives mem_we=1 in the cycle after edge N. With mem_ready held high, throughput is one pixel per cycle.
- FIFO full:
  - A push with a simultaneous pop in the same cycle is accepted.
  - A push to a full FIFO with no pop drops the pixel, sets overflow (sticky until next accepted _start), and does not change either counter.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.

Test Plan:
- Reset, color=0x2A, _start. Stream (1,2),(2,2),(3,2),(4,2), in_done with the last coordinate, mem_ready=1 -> writes addr 129,130,131,132, data 0x2A, one per cycle; pixel_count=4, clip_count=0; _done high one cycle after the last write.
- Clipping: (-1,0),(64,5),(5,48),(63,47),(0,0) -> writes to addr 3071 then 0 only; clip_count=3, pixel_count=2.
- Backpressure: mem_ready=0 while 3 pixels arrive, then mem_ready=1 -> mem_addr/mem_data stable while stalled; all 3 written in order; no overflow.
- Overflow: mem_ready=0, 10 consecutive in-range pixels, FIFO_DEPTH=8 -> 8 buffered, overflow=1; after release pixel_count=8. A push on a full FIFO in a cycle where mem_ready=1 is accepted, with no overflow.
- Empty shape and restart: _start then in_done alone -> DONE one cycle later with counters 0. A _start asserted during RUN is ignored. A second _start from DONE clears _done and the counters.
- Reset mid-shape: _reset_n=0 for one edge while 4 pixels are buffered -> mem_we=0, state IDLE, counters 0. A subsequent shape works normally.
